fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-cycle RV32IM hart: owns the program counter, drives `Program_Count` into `instruct_mem`, and captures the combinational `Instruction` it returns. Fetched {pc, instruction} pairs are held in a small FIFO and handed to decode over a valid/ready handshake. Handles redirects from execute (branch/jump/trap), the custom halt word 32'h0000007F, and misaligned redirect targets.

## Interface
- `DWIDTH`, 32: PC / address width.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `BUF_DEPTH`, 2: fetch FIFO entries, power of two, ≥2.

Ports:
- `Clk_Core` in 1: core clock, all state on rising edge.
- `Rst_Core_N` in 1: asynchronous active-low reset.
- `Program_Count` out DWIDTH: fetch address to `instruct_mem`; equals the PC register.
- `Instruction_In` in 32: word returned by `instruct_mem` for `Program_Count`, same cycle.
- `Redirect_Valid` in 1: execute requests a new fetch address.
- `Redirect_Target` in DWIDTH: new fetch address.
- `Instr_Valid` out 1: FIFO head is valid.
- `Instr_Ready` in 1: decode accepts the head.
- `Instr_Out` out 32: head instruction.
- `Instr_Pc` out DWIDTH: PC of head instruction.
- `Halted` out 1: fetch stopped on halt word.
- `Fetch_Fault` out 1: sticky misaligned-redirect fault.

## Operation
- States: FETCH, HALT, FAULT.
- Enqueue condition (FETCH only): `count < BUF_DEPTH` or a dequeue occurs this cycle, and no redirect. On enqueue: push {PC, `Instruction_In`}, PC <= PC + 4 (wraps modulo 2^DWIDTH).
- Dequeue: `Instr_Valid && Instr_Ready`; head pops.
- Enqueue of 32'h0000007F: word is pushed normally (decode sees it), PC not advanced, state -> HALT. HALT: no enqueue, PC frozen, `Halted`=1; dequeue continues.
- Redirect (priority over everything): FIFO flushed (count <= 0, including entry being dequeued this cycle, which counts as consumed), no enqueue this cycle.
  - `Redirect_Target[1:0]==0`: PC <= target, state -> FETCH (from FETCH or HALT).
  - Otherwise: PC unchanged, state -> FAULT, `Fetch_Fault`=1.
- FAULT: no enqueue, FIFO stays empty, redirects ignored; exits only via reset.
- Full with no dequeue: PC holds, `Instruction_In` re-read next cycle (async ROM, no loss).

## Timing
- Reset values: PC/`Program_Count`=RESET_VECTOR, `Instr_Valid`=0, `Instr_Out`=0, `Instr_Pc`=0, `Halted`=0, `Fetch_Fault`=0, state FETCH, FIFO empty.
- Reset assertion mid-operation clears everything immediately (async); first enqueue on first rising edge after deassertion.
- Latency: word at PC fetched in cycle n is `Instr_Out` in cycle n+1 when FIFO was empty; outputs come from registered FIFO, no combinational path from `Instruction_In` or `Redirect_*` to `Instr_*`.
- Redirect in cycle n: `Instr_Valid`=0 in n+1, target's instruction valid in n+2.
- Throughput: one instruction/cycle with `Instr_Ready` held high, including when full (simultaneous push/pop).
- `Instr_Out`/`Instr_Pc` stable while `Instr_Valid && !Instr_Ready`.

## Structure
- `fetch_pkg`: `fetch_state_e` {FETCH, HALT, FAULT}, `HALT_INSTR`=32'h0000007F, `fetch_entry_t` struct {pc, instr}.
- Sub-module `fetch_buffer`: synchronous FIFO of `fetch_entry_t` with push/pop/flush, full/empty, simultaneous push+pop when full; async active-low reset.
- Top: PC register, state machine, enqueue/redirect logic.

## Test plan
- Reset, `Instr_Ready`=1, ROM 0..3 = 0x00c00513, 0x010000ef, 0x00a02023, 0x00000013 -> `Instr_Pc` 0,4,8,0xC on consecutive cycles from cycle 1, `Instr_Out` matching.
- `Instr_Ready`=0 for 5 cycles -> `Instr_Valid`=1, count saturates at 2, `Program_Count`=8 held; release -> PCs 0,4,8 in order, none lost or duplicated.
- Redirect to 0x34 while FIFO full -> next cycle `Instr_Valid`=0, following cycle `Instr_Pc`=0x34 with ROM[13].
- ROM[4]=0x0000007F -> entry pc 0x10 delivered, `Halted`=1, `Program_Count` stays 0x10; redirect to 0x14 -> `Halted`=0, fetch resumes at 0x14.
- Redirect to 0x22 -> `Fetch_Fault`=1, `Instr_Valid`=0, later redirect to 0x0 ignored; assert `Rst_Core_N` mid-cycle -> all outputs at reset values immediately.
- Redirect and dequeue same cycle -> dequeued entry not re-presented, target fetched 2 cycles later.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] HALT_INSTR = 32'h0000_007F;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO of fetched {pc, instr} entries
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, fetch state machine and decode-side handshake
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
  parameter int                BUF_DEPTH    = 2
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  output logic [DWIDTH-1:0] Program_Count,
  input  logic [31:0]       Instruction_In,
  input  logic              Redirect_Valid,
  input  logic [DWIDTH-1:0] Redirect_Target,
  output logic              Instr_Valid,
  input  logic              Instr_Ready,
  output logic [31:0]       Instr_Out,
  output logic [DWIDTH-1:0] Instr_Pc,
  output logic              Halted,
  output logic              Fetch_Fault
);

  logic [DWIDTH-1:0] pc;
  fetch_state_e      state;
  logic              halted_q;
  logic              fault_q;
  fetch_entry_t      push_data;
  fetch_entry_t      head;
  logic              full;
  logic              empty;
  logic              deq;
  logic              push;
  logic              flush;

  assign Program_Count = pc;
  assign deq   = !empty && Instr_Ready;
  assign flush = Redirect_Valid && (state != FAULT);
  assign push  = (state == FETCH) && !Redirect_Valid && (!full || deq);

  assign push_data.pc    = PC_W'(pc);
  assign push_data.instr = Instruction_In;

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk       (Clk_Core),
    .rst_n     (Rst_Core_N),
    .push      (push),
    .push_data (push_data),
    .pop       (deq),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Stale storage is masked so an empty buffer always presents zeros.
  assign Instr_Valid = !empty;
  assign Instr_Out   = empty ? '0 : head.instr;
  assign Instr_Pc    = empty ? '0 : DWIDTH'(head.pc);
  assign Halted      = halted_q;
  assign Fetch_Fault = fault_q;

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      pc       <= RESET_VECTOR;
      state    <= FETCH;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        FETCH, HALT: begin
          if (Redirect_Valid) begin
            halted_q <= 1'b0;
            if (Redirect_Target[1:0] == 2'b00) begin
              pc    <= Redirect_Target;
              state <= FETCH;
            end else begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end
          end else if (push) begin
            // The halt word still goes to decode, but the PC stays on it.
            if (Instruction_In == HALT_INSTR) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc <= pc + DWIDTH'(4);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        Clk_Core;
  logic        Rst_Core_N;
  logic [31:0] Program_Count;
  logic [31:0] Instruction_In;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr_Out;
  logic [31:0] Instr_Pc;
  logic        Halted;
  logic        Fetch_Fault;

  logic [31:0] rom [64];
  assign Instruction_In = rom[Program_Count[7:2]];

  fetch_unit #(
    .DWIDTH(32),
    .RESET_VECTOR(32'h0),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .Clk_Core        (Clk_Core),
    .Rst_Core_N      (Rst_Core_N),
    .Program_Count   (Program_Count),
    .Instruction_In  (Instruction_In),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .Instr_Valid     (Instr_Valid),
    .Instr_Ready     (Instr_Ready),
    .Instr_Out       (Instr_Out),
    .Instr_Pc        (Instr_Pc),
    .Halted          (Halted),
    .Fetch_Fault     (Fetch_Fault)
  );

  initial Clk_Core = 1'b0;
  always #5 Clk_Core = ~Clk_Core;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_st;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rv, input logic [31:0] tgt, input logic rdy);
    logic [31:0] w;
    bit          deq;
    deq = (q.size() > 0) && rdy;
    if (m_st != 2 && rv) begin
      q.delete();
      if (tgt[1:0] == 2'b00) begin
        m_pc = tgt;
        m_st = 0;
      end else begin
        m_st = 2;
      end
    end else begin
      w = rom[m_pc[7:2]];
      if (deq) void'(q.pop_front());
      if (m_st == 0 && q.size() < DEPTH) begin
        q.push_back('{pc: m_pc, instr: w});
        if (w == 32'h0000_007F) m_st = 1;
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(Instr_Valid), 32'(q.size() > 0));
    check("program_count", Program_Count, m_pc);
    check("halted", 32'(Halted), 32'(m_st == 1));
    check("fault", 32'(Fetch_Fault), 32'(m_st == 2));
    if (q.size() > 0) begin
      check("instr_pc", Instr_Pc, q[0].pc);
      check("instr_out", Instr_Out, q[0].instr);
    end
  endtask

  task automatic cycle(input logic rv, input logic [31:0] tgt, input logic rdy);
    Redirect_Valid  = rv;
    Redirect_Target = tgt;
    Instr_Ready     = rdy;
    @(posedge Clk_Core);
    model_step(rv, tgt, rdy);
    @(negedge Clk_Core);
    compare_all();
  endtask

  // Reset is asserted between edges so its effect must be immediate.
  task automatic do_reset();
    Rst_Core_N = 1'b0;
    #2;
    q.delete();
    m_pc = 32'h0;
    m_st = 0;
    check("rst_pc", Program_Count, 32'h0);
    check("rst_valid", 32'(Instr_Valid), 32'h0);
    check("rst_out", Instr_Out, 32'h0);
    check("rst_ipc", Instr_Pc, 32'h0);
    check("rst_halted", 32'(Halted), 32'h0);
    check("rst_fault", 32'(Fetch_Fault), 32'h0);
    @(negedge Clk_Core);
    Rst_Core_N = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] tgt;
    int          fault_cyc;

    Rst_Core_N      = 1'b0;
    Redirect_Valid  = 1'b0;
    Redirect_Target = 32'h0;
    Instr_Ready     = 1'b0;
    for (int k = 0; k < 64; k++) begin
      w = $urandom;
      if (w == 32'h0000_007F) w = 32'h0000_0013;
      rom[k] = w;
    end
    rom[0] = 32'h00c0_0513;
    rom[1] = 32'h0100_00ef;
    rom[2] = 32'h00a0_2023;
    rom[3] = 32'h0000_0013;
    rom[4] = 32'h0000_007F;

    do_reset();

    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check("seq_pc", Instr_Pc, 32'(i * 4));
      check("seq_out", Instr_Out, rom[i]);
    end

    do_reset();
    repeat (5) cycle(1'b0, 32'h0, 1'b0);
    check("stall_pc", Program_Count, 32'h8);
    check("stall_valid", 32'(Instr_Valid), 32'h1);
    check("stall_head", Instr_Pc, 32'h0);
    for (int i = 1; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check("release_pc", Instr_Pc, 32'(i * 4));
    end

    repeat (2) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h34, 1'b0);
    check("redir_flush", 32'(Instr_Valid), 32'h0);
    cycle(1'b0, 32'h0, 1'b0);
    check("redir_pc", Instr_Pc, 32'h34);
    check("redir_out", Instr_Out, rom[13]);

    cycle(1'b1, 32'h10, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("halt_flag", 32'(Halted), 32'h1);
    check("halt_entry_pc", Instr_Pc, 32'h10);
    check("halt_entry", Instr_Out, 32'h0000_007F);
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    check("halt_hold", Program_Count, 32'h10);
    cycle(1'b1, 32'h14, 1'b1);
    check("halt_exit", 32'(Halted), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    check("resume_pc", Instr_Pc, 32'h14);

    cycle(1'b1, 32'h40, 1'b1);
    check("redir_deq_flush", 32'(Instr_Valid), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    check("redir_deq_pc", Instr_Pc, 32'h40);

    cycle(1'b1, 32'h22, 1'b1);
    check("fault_set", 32'(Fetch_Fault), 32'h1);
    cycle(1'b1, 32'h0, 1'b1);
    check("fault_sticky", 32'(Fetch_Fault), 32'h1);
    check("fault_empty", 32'(Instr_Valid), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    do_reset();

    for (int k = 0; k < 64; k++) begin
      w = $urandom;
      if ($urandom_range(0, 11) == 0) w = 32'h0000_007F;
      else if (w == 32'h0000_007F) w = 32'h0000_0013;
      rom[k] = w;
    end
    do_reset();
    fault_cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      tgt = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      cycle($urandom_range(0, 11) == 0, tgt, $urandom_range(0, 3) != 0);
      if (m_st == 2) begin
        fault_cyc++;
        if (fault_cyc > 4) begin
          do_reset();
          fault_cyc = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
